// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle control FSM: state encoding,
// opcode constants, ALU operation and PC source encodings.
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h11;
    localparam logic [5:0] OP_SW    = 6'h12;
    localparam logic [5:0] OP_BEQ   = 6'h13;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;

    // Opcodes that proceed from DECODE to EXEC.
    function automatic logic is_exec_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW)    || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Memory wait timer shared by the FETCH and MEM waits.
//   clk, rst_n : core clock, synchronous active-low reset
//   clear      : restart the count (asserted on every state change)
//   en         : count this cycle (asserted while waiting on a memory)
//   expired    : this is the MEM_TO_W-th waiting cycle; never set when MEM_TO_W = 0
module mem_wait_timer #(
    parameter int unsigned MEM_TO_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned TW = (MEM_TO_W > 2) ? $clog2(MEM_TO_W) : 1;

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TW'(1);
        end
    end

    // cnt holds (cycles already waited); the limit cycle is cnt == MEM_TO_W-1.
    assign expired = (MEM_TO_W != 0) && (cnt == TW'(MEM_TO_W - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
// Inputs : clk, rst_n (sync, active low), start, opcode[5:0] (from IR),
//          alu_zero, imem_ready, dmem_ready.
// Outputs: imem_req, ir_load, pc_en, pc_src[1:0], alu_src_imm, alu_op[2:0],
//          dmem_req, dmem_we, rf_we, rf_dst_sel, wb_sel, halted,
//          fault[1:0] (sticky: bit0 illegal opcode, bit1 memory timeout),
//          retired[CNT_W-1:0] (completed instruction count, wraps).
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MEM_TO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_imm,
    output logic [2:0]       alu_op,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             rf_dst_sel,
    output logic             wb_sel,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    state_t     state, state_d;
    logic       retire;
    logic [1:0] fault_set;
    logic       to_expired;

    // Any state change restarts the wait count, so each FETCH/MEM entry starts at zero.
    mem_wait_timer #(
        .MEM_TO_W (MEM_TO_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_d != state),
        .en      ((state == ST_FETCH) || (state == ST_MEM)),
        .expired (to_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            fault   <= '0;
            retired <= '0;
        end else begin
            state <= state_d;
            fault <= fault | fault_set;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state;
        retire      = 1'b0;
        fault_set   = '0;
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        pc_en       = 1'b0;
        pc_src      = PC_SEQ;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        rf_dst_sel  = 1'b0;
        wb_sel      = 1'b0;
        halted      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                // Ready takes priority over the timeout on the limit cycle.
                if (imem_ready) begin
                    ir_load = 1'b1;
                    pc_en   = 1'b1;
                    pc_src  = PC_SEQ;
                    state_d = ST_DECODE;
                end else if (to_expired) begin
                    fault_set[1] = 1'b1;
                    state_d      = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (is_exec_op(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    fault_set[0] = 1'b1;
                    state_d      = ST_FETCH;
                end
            end
            ST_EXEC: begin
                alu_src_imm = opcode[4];
                if (opcode == OP_RTYPE) begin
                    alu_op = ALU_FUNCT;
                end else if (opcode == OP_BEQ) begin
                    alu_op = ALU_SUB;
                end
                if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_d = ST_MEM;
                end else if (opcode == OP_BEQ) begin
                    if (alu_zero) begin
                        pc_en  = 1'b1;
                        pc_src = PC_BRANCH;
                    end
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_SW);
                if (dmem_ready) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (to_expired) begin
                    fault_set[1] = 1'b1;
                    state_d      = ST_HALT;
                end
            end
            ST_WB: begin
                rf_we      = 1'b1;
                rf_dst_sel = opcode[4];
                wb_sel     = (opcode == OP_LW);
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n, start, alu_zero, imem_ready, dmem_ready;
    logic [5:0] opcode;
    logic       imem_req, ir_load, pc_en, alu_src_imm, dmem_req, dmem_we;
    logic       rf_we, rf_dst_sel, wb_sel, halted;
    logic [1:0] pc_src, fault;
    logic [2:0] alu_op;
    logic [7:0] retired;

    int checks   = 0;
    int failures = 0;

    multicycle_controller #(
        .CNT_W    (8),
        .MEM_TO_W (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .opcode      (opcode),
        .alu_zero    (alu_zero),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .alu_src_imm (alu_src_imm),
        .alu_op      (alu_op),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .rf_we       (rf_we),
        .rf_dst_sel  (rf_dst_sel),
        .wb_sel      (wb_sel),
        .halted      (halted),
        .fault       (fault),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    logic [14:0] ctrl;
    assign ctrl = {imem_req, ir_load, pc_en, pc_src, alu_src_imm, alu_op,
                   dmem_req, dmem_we, rf_we, rf_dst_sel, wb_sel, halted};

    function automatic logic [14:0] mk(input logic ireq, input logic irl, input logic pce,
                                       input logic [1:0] psrc, input logic asrc,
                                       input logic [2:0] aop, input logic dreq,
                                       input logic dwe, input logic rfwe, input logic dst,
                                       input logic wbs, input logic hlt);
        return {ireq, irl, pce, psrc, asrc, aop, dreq, dwe, rfwe, dst, wbs, hlt};
    endfunction

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic check_next(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow observed=%0h", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expect_val(tag, exp);
        check_next(obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [14:0] c_zero, c_fetch, c_fwait, c_halt;

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        c_zero  = '0;
        c_fetch = mk(1, 1, 1, 2'd0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
        c_fwait = mk(1, 0, 0, 2'd0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
        c_halt  = mk(0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 0, 0, 0, 1);

        rst_n = 1'b0; start = 1'b0; alu_zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 6'h00;
        tick(); tick();

        // Reset state (IDLE), then start
        rst_n = 1'b1; start = 1'b1; #1;
        chk("rst_ctrl", 32'(ctrl), 32'(c_zero));
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);

        // RTYPE, zero-wait memory
        tick(); start = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = 6'h00; #1;
        chk("rt_fetch", 32'(ctrl), 32'(c_fetch));
        tick(); #1; chk("rt_decode", 32'(ctrl), 32'(c_zero));
        tick(); #1; chk("rt_exec", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 0, 3'd2, 0, 0, 0, 0, 0, 0)));
        tick(); #1; chk("rt_wb", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 1, 0, 0, 0)));

        // LW with dmem_ready arriving in the third MEM cycle
        tick(); opcode = 6'h11; dmem_ready = 1'b0; #1;
        chk("rt_retired", 32'(retired), 32'd1);
        chk("lw_fetch", 32'(ctrl), 32'(c_fetch));
        tick(); #1;
        tick(); #1; chk("lw_exec", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 1, 3'd0, 0, 0, 0, 0, 0, 0)));
        tick(); #1; chk("lw_mem1", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 0, 3'd0, 1, 0, 0, 0, 0, 0)));
        tick(); #1; chk("lw_mem2", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 0, 3'd0, 1, 0, 0, 0, 0, 0)));
        tick(); dmem_ready = 1'b1; #1;
        chk("lw_mem3", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 0, 3'd0, 1, 0, 0, 0, 0, 0)));
        tick(); dmem_ready = 1'b0; #1;
        chk("lw_wb", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 1, 1, 1, 0)));

        // SW with ready on the timeout-limit cycle: ready wins
        tick(); opcode = 6'h12; #1;
        chk("lw_retired", 32'(retired), 32'd2);
        tick(); #1;
        tick(); #1;
        tick(); #1; tick(); #1; tick(); #1;
        chk("sw_mem3", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 0, 3'd0, 1, 1, 0, 0, 0, 0)));
        tick(); dmem_ready = 1'b1; #1;
        chk("sw_mem4", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 0, 3'd0, 1, 1, 0, 0, 0, 0)));
        tick(); dmem_ready = 1'b0; opcode = 6'h13; alu_zero = 1'b1; #1;
        chk("sw_nofault", 32'(fault), 32'd0);
        chk("sw_retired", 32'(retired), 32'd3);
        chk("sw_fetch", 32'(ctrl), 32'(c_fetch));

        // BEQ taken then not taken
        tick(); #1;
        tick(); #1; chk("beq_t_exec", 32'(ctrl), 32'(mk(0, 0, 1, 2'd1, 1, 3'd1, 0, 0, 0, 0, 0, 0)));
        tick(); alu_zero = 1'b0; #1;
        chk("beq_t_retired", 32'(retired), 32'd4);
        tick(); #1;
        tick(); #1; chk("beq_n_exec", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 1, 3'd1, 0, 0, 0, 0, 0, 0)));

        // Illegal opcode
        tick(); opcode = 6'h05; #1;
        chk("beq_n_retired", 32'(retired), 32'd5);
        tick(); #1; chk("ill_decode", 32'(ctrl), 32'(c_zero));
        tick(); opcode = 6'h10; #1;
        chk("ill_fault", 32'(fault), 32'd1);
        chk("ill_retired", 32'(retired), 32'd5);
        chk("ill_refetch", 32'(ctrl), 32'(c_fetch));

        // ADDI
        tick(); #1;
        tick(); #1; chk("addi_exec", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 1, 3'd0, 0, 0, 0, 0, 0, 0)));
        tick(); #1; chk("addi_wb", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 0, 3'd0, 0, 0, 1, 1, 0, 0)));

        // SW with reset applied during the MEM wait
        tick(); opcode = 6'h12; dmem_ready = 1'b0; #1;
        chk("addi_retired", 32'(retired), 32'd6);
        tick(); #1;
        tick(); #1;
        tick(); #1; chk("swr_mem1", 32'(ctrl), 32'(mk(0, 0, 0, 2'd0, 0, 3'd0, 1, 1, 0, 0, 0, 0)));
        tick(); rst_n = 1'b0; #1;
        tick(); rst_n = 1'b1; #1;
        chk("swr_ctrl", 32'(ctrl), 32'(c_zero));
        chk("swr_retired", 32'(retired), 32'd0);
        chk("swr_fault", 32'(fault), 32'd0);
        tick(); start = 1'b1; #1;
        chk("swr_idle", 32'(ctrl), 32'(c_zero));

        // Retire counter wrap with 256 untaken BEQs
        tick(); start = 1'b0; opcode = 6'h13; alu_zero = 1'b0; #1;
        for (int i = 1; i <= 256; i++) begin
            tick(); tick(); tick(); #1;
            if (i == 255) chk("wrap_255", 32'(retired), 32'd255);
        end
        chk("wrap_0", 32'(retired), 32'd0);

        // One more BEQ, then an instruction fetch that never completes
        tick(); imem_ready = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        chk("to_retired", 32'(retired), 32'd1);
        chk("to_fetch1", 32'(ctrl), 32'(c_fwait));
        tick(); #1; tick(); #1; tick(); #1;
        chk("to_fetch4", 32'(ctrl), 32'(c_fwait));
        chk("to_nofault_yet", 32'(fault), 32'd0);
        tick(); start = 1'b1; imem_ready = 1'b1; #1;
        chk("to_halt", 32'(ctrl), 32'(c_halt));
        chk("to_fault", 32'(fault), 32'd2);
        tick(); #1;
        chk("halt_stays", 32'(ctrl), 32'(c_halt));
        chk("halt_retired", 32'(retired), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
